// File: rtl/serial_adder_fsm_if.sv
// Operand/result bundle for serial_adder_fsm: request side (master) and adder side (slave).
// Carries the ovf result only when SIGNED_OVF_EN is defined.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell built from two half-adder cells plus a carry flop.
// Optional feature macro: SIGNED_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_adder_fsm_if.slave    io_bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of a single half-adder cell.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic [1:0]         w_fa;
  logic               w_s_bit;
  logic               w_carry_nxt;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_s_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;
`ifdef SIGNED_OVF_EN
  logic               r_ovf;
`endif

  assign w_fa        = full_add(r_a_sh[0], r_b_sh[0], r_carry);
  assign w_s_bit     = w_fa[0];
  assign w_carry_nxt = w_fa[1];
  assign w_last      = (r_cnt == CNT_LAST);

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they track it exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand shifters, carry, bit counter and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_sh  <= {WIDTH{1'b0}};
      r_b_sh  <= {WIDTH{1'b0}};
      r_s_sh  <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_load) begin
      r_a_sh  <= io_bus.a;
      r_b_sh  <= io_bus.b;
      r_carry <= io_bus.cin;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_shift) begin
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_s_sh  <= {w_s_bit, r_s_sh[WIDTH-1:1]};
      r_carry <= w_carry_nxt;
      r_cnt   <= w_last ? r_cnt : (r_cnt + CNT_W'(1));
      if (w_last) begin
        r_sum  <= {w_s_bit, r_s_sh[WIDTH-1:1]};
        r_cout <= w_carry_nxt;
`ifdef SIGNED_OVF_EN
        // On the MSB step r_carry is the carry into the MSB.
        r_ovf  <= r_carry ^ w_carry_nxt;
`endif
      end
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
`ifdef SIGNED_OVF_EN
  assign io_bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm (WIDTH=8) against a plain-arithmetic reference.
// Define SIGNED_OVF_EN to also check the overflow flag.
module tb_serial_adder_fsm;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_adder_fsm_if #(.WIDTH(W)) bus ();

  serial_adder_fsm #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision sum, plus signed overflow from operand/result signs.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] r;
    r = ref_add(a, b, cin);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  function automatic logic read_ovf();
`ifdef SIGNED_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Issues one start and waits (bounded) for done; lat counts edges after the start edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov,
                       output int lat, output logic busy1, output logic stable);
    logic [W-1:0] prev;
    prev       = bus.sum;
    bus.a      = a;
    bus.b      = b;
    bus.cin    = cin;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    busy1      = bus.busy;
    stable     = 1'b1;
    lat        = 0;
    while (bus.done !== 1'b1 && lat < 4 * W) begin
      if (bus.sum !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    s  = bus.sum;
    co = bus.cout;
    ov = read_ovf();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef SIGNED_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ov, b1, st; int lat;
    do_op(8'h3C, 8'h05, 1'b0, s, co, ov, lat, b1, st);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", b1); end
    checks++; if (lat != W) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    checks++; if (s !== 8'h41) begin errors++; $display("FAIL basic_sum got=%h exp=41", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", co); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after done=%b busy=%b exp=0/0", bus.done, bus.busy);
    end
`ifdef SIGNED_OVF_EN
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", ov); end
`endif
  endtask

  task automatic test_carry();
    logic [W-1:0] s; logic co, ov, b1, st; int lat;
    do_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat, b1, st);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff01 got=%b_%h exp=1_00", co, s); end
`ifdef SIGNED_OVF_EN
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL carry_ff01_ovf got=%b exp=0", ov); end
`endif
    do_op(8'hFF, 8'h00, 1'b1, s, co, ov, lat, b1, st);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_cin got=%b_%h exp=1_00", co, s); end
  endtask

  task automatic test_ovf();
    logic [W-1:0] s; logic co, ov, b1, st; int lat;
    do_op(8'h7F, 8'h01, 1'b0, s, co, ov, lat, b1, st);
    checks++; if ({co, s} !== 9'h080) begin errors++; $display("FAIL ovf_7f01 got=%b_%h exp=0_80", co, s); end
`ifdef SIGNED_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_7f01_flag got=%b exp=1", ov); end
`endif
    do_op(8'h80, 8'h80, 1'b0, s, co, ov, lat, b1, st);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL ovf_8080 got=%b_%h exp=1_00", co, s); end
`ifdef SIGNED_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_8080_flag got=%b exp=1", ov); end
`endif
  endtask

  task automatic test_ignore_start();
    int ndone; logic [W-1:0] s;
    ndone     = 0;
    s         = '0;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.a     = 8'hAA;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (bus.done === 1'b1) begin ndone++; s = bus.sum; end
      @(posedge clk); #1;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (s !== 8'h33) begin errors++; $display("FAIL ignore_sum got=%h exp=33", s); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic co, ov, b1, st; int lat;
    bus.a     = 8'hC3;
    bus.b     = 8'h5A;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs busy=%b done=%b cout=%b sum=%h exp=0", bus.busy, bus.done, bus.cout, bus.sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(8'h01, 8'h02, 1'b0, s, co, ov, lat, b1, st);
    checks++; if ({co, s} !== 9'h003) begin errors++; $display("FAIL midrst_sum got=%b_%h exp=0_03", co, s); end
    checks++; if (lat != W) begin errors++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, W); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, a, b; logic co, ov, b1, st, ci; int lat; logic [W:0] e;
    for (int n = 0; n < 1000; n++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      e  = ref_add(a, b, ci);
      do_op(a, b, ci, s, co, ov, lat, b1, st);
      checks++; if ({co, s} !== e) begin
        errors++; $display("FAIL rand_result a=%h b=%h cin=%b got=%b_%h exp=%b_%h", a, b, ci, co, s, e[W], e[W-1:0]);
      end
      checks++; if (lat != W) begin errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, W); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand_sum_stable got=%b exp=1", st); end
`ifdef SIGNED_OVF_EN
      checks++; if (ov !== ref_ovf(a, b, ci)) begin
        errors++; $display("FAIL rand_ovf a=%h b=%h cin=%b got=%b exp=%b", a, b, ci, ov, ref_ovf(a, b, ci));
      end
`endif
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ovf();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
